// File: rtl/ysyx_22040759_exe_stage.sv
// EXE pipeline stage: one input register holding the decoded instruction, then a
// purely combinational operand-forwarding, ALU and branch-resolution datapath.
module ysyx_22040759_exe_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         ms_allowin,
  input  logic         ds_to_es_valid,
  input  logic [322:0] ds_to_es_bus,
  input  logic [1:0]   ForwardA,
  input  logic [1:0]   ForwardB,
  input  logic [63:0]  ms_alu_result,
  input  logic [63:0]  ws_alu_result,
  output logic         es_allowin,
  output logic [4:0]   es_rs1,
  output logic [4:0]   es_rs2,
  output logic         es_to_ms_valid,
  output logic [172:0] es_to_ms_bus,
  output logic [63:0]  alu_result,
  output logic [130:0] bru_to_fs_bus
);

  // Handshake: a stage holding valid data passes it on when the consumer's
  // allowin is high; this stage always completes in one cycle (ready_go = 1).
  logic         es_valid;
  logic [322:0] es_bus;

  assign es_allowin     = !es_valid || ms_allowin;
  assign es_to_ms_valid = es_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      es_valid <= 1'b0;
      es_bus   <= '0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
      if (ds_to_es_valid) es_bus <= ds_to_es_bus;
    end
  end

  logic [63:0] pc, rs1_val, rs2_val, imm;
  logic [31:0] inst;
  logic [4:0]  rs1, rs2, rd, alu_op;
  logic [1:0]  src1_sel;
  logic [2:0]  mem_size, br_type;
  logic        src2_sel, mem_read, mem_write, reg_write, word_op, jal, jalr;

  assign pc        = es_bus[63:0];
  assign rs1_val   = es_bus[127:64];
  assign rs2_val   = es_bus[191:128];
  assign imm       = es_bus[255:192];
  assign inst      = es_bus[287:256];
  assign rs1       = es_bus[292:288];
  assign rs2       = es_bus[297:293];
  assign rd        = es_bus[302:298];
  assign alu_op    = es_bus[307:303];
  assign src1_sel  = es_bus[309:308];
  assign src2_sel  = es_bus[310];
  assign mem_read  = es_bus[311];
  assign mem_write = es_bus[312];
  assign mem_size  = es_bus[315:313];
  assign reg_write = es_bus[316];
  assign word_op   = es_bus[317];
  assign br_type   = es_bus[320:318];
  assign jal       = es_bus[321];
  assign jalr      = es_bus[322];

  assign es_rs1 = rs1;
  assign es_rs2 = rs2;

  logic [63:0] op_a, op_b, src1, src2;

  always_comb begin
    case (ForwardA)
      2'b10:   op_a = ms_alu_result;
      2'b01:   op_a = ws_alu_result;
      default: op_a = rs1_val;
    endcase
    case (ForwardB)
      2'b10:   op_b = ms_alu_result;
      2'b01:   op_b = ws_alu_result;
      default: op_b = rs2_val;
    endcase
    case (src1_sel)
      2'b00:   src1 = op_a;
      2'b01:   src1 = pc;
      default: src1 = 64'd0;
    endcase
    src2 = src2_sel ? imm : op_b;
  end

  // Divisors are replaced by 1 on divide-by-zero or min/-1 overflow so the
  // dividers never see those cases; the special results are muxed in after.
  logic        dz_d, ov_d, dz_w, ov_w;
  logic [63:0] dvs_sd, dvs_ud, q_s_d, r_s_d, q_u_d, r_u_d;
  logic [31:0] a_w, b_w, dvs_sw, dvs_uw, q_s_w, r_s_w, q_u_w, r_u_w;

  assign a_w  = src1[31:0];
  assign b_w  = src2[31:0];
  assign dz_d = (src2 == 64'd0);
  assign ov_d = (src1 == 64'h8000_0000_0000_0000) && (src2 == {64{1'b1}});
  assign dz_w = (b_w == 32'd0);
  assign ov_w = (a_w == 32'h8000_0000) && (b_w == 32'hFFFF_FFFF);

  assign dvs_sd = (dz_d || ov_d) ? 64'd1 : src2;
  assign dvs_ud = dz_d ? 64'd1 : src2;
  assign dvs_sw = (dz_w || ov_w) ? 32'd1 : b_w;
  assign dvs_uw = dz_w ? 32'd1 : b_w;

  assign q_s_d = $signed(src1) / $signed(dvs_sd);
  assign r_s_d = $signed(src1) % $signed(dvs_sd);
  assign q_u_d = src1 / dvs_ud;
  assign r_u_d = src1 % dvs_ud;
  assign q_s_w = $signed(a_w) / $signed(dvs_sw);
  assign r_s_w = $signed(a_w) % $signed(dvs_sw);
  assign q_u_w = a_w / dvs_uw;
  assign r_u_w = a_w % dvs_uw;

  logic [63:0] res_d;
  logic [31:0] res_w;

  always_comb begin
    res_d = 64'd0;
    case (alu_op)
      5'd0:  res_d = src1 + src2;
      5'd1:  res_d = src1 - src2;
      5'd2:  res_d = src1 << src2[5:0];
      5'd3:  res_d = {63'd0, $signed(src1) < $signed(src2)};
      5'd4:  res_d = {63'd0, src1 < src2};
      5'd5:  res_d = src1 ^ src2;
      5'd6:  res_d = src1 >> src2[5:0];
      5'd7:  res_d = $unsigned($signed(src1) >>> src2[5:0]);
      5'd8:  res_d = src1 | src2;
      5'd9:  res_d = src1 & src2;
      5'd10: res_d = src2;
      5'd11: res_d = src1 * src2;
      5'd12: res_d = dz_d ? {64{1'b1}} : (ov_d ? src1 : q_s_d);
      5'd13: res_d = dz_d ? {64{1'b1}} : q_u_d;
      5'd14: res_d = dz_d ? src1 : (ov_d ? 64'd0 : r_s_d);
      5'd15: res_d = dz_d ? src1 : r_u_d;
      default: res_d = 64'd0;
    endcase
  end

  always_comb begin
    res_w = 32'd0;
    case (alu_op)
      5'd0:  res_w = a_w + b_w;
      5'd1:  res_w = a_w - b_w;
      5'd2:  res_w = a_w << b_w[4:0];
      5'd3:  res_w = {31'd0, $signed(a_w) < $signed(b_w)};
      5'd4:  res_w = {31'd0, a_w < b_w};
      5'd5:  res_w = a_w ^ b_w;
      5'd6:  res_w = a_w >> b_w[4:0];
      5'd7:  res_w = $unsigned($signed(a_w) >>> b_w[4:0]);
      5'd8:  res_w = a_w | b_w;
      5'd9:  res_w = a_w & b_w;
      5'd10: res_w = b_w;
      5'd11: res_w = a_w * b_w;
      5'd12: res_w = dz_w ? 32'hFFFF_FFFF : (ov_w ? a_w : q_s_w);
      5'd13: res_w = dz_w ? 32'hFFFF_FFFF : q_u_w;
      5'd14: res_w = dz_w ? a_w : (ov_w ? 32'd0 : r_s_w);
      5'd15: res_w = dz_w ? a_w : r_u_w;
      default: res_w = 32'd0;
    endcase
  end

  logic jump;
  assign jump = jal || jalr;

  always_comb begin
    if (jump)         alu_result = pc + 64'd4;
    else if (word_op) alu_result = {{32{res_w[31]}}, res_w};
    else              alu_result = res_d;
  end

  logic br_eq, br_lt, br_ltu, br_cond, taken;
  logic [63:0] target;

  assign br_eq  = (op_a == op_b);
  assign br_lt  = $signed(op_a) < $signed(op_b);
  assign br_ltu = op_a < op_b;

  always_comb begin
    case (br_type)
      3'b001:  br_cond = br_eq;
      3'b010:  br_cond = !br_eq;
      3'b011:  br_cond = br_lt;
      3'b100:  br_cond = !br_lt;
      3'b101:  br_cond = br_ltu;
      3'b110:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = es_valid && (jump || br_cond);
  assign target = jalr ? ((op_a + imm) & ~64'd1) : (pc + imm);

  assign bru_to_fs_bus = {es_valid, es_valid && jump, pc, taken, target};
  assign es_to_ms_bus  = {inst, 1'b0, pc, mem_read, jump, mem_write,
                          mem_size, reg_write, rd, op_b};

endmodule

// File: tb/tb_ysyx_22040759_exe_stage.sv
// Bench for the EXE stage: directed and random instructions through a scoreboard
// of expected ALU/branch/store results, plus reset and back-pressure cases.
module tb_ysyx_22040759_exe_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ms_allowin = 1'b1;
  logic         ds_to_es_valid = 1'b0;
  logic [322:0] ds_to_es_bus = '0;
  logic [1:0]   ForwardA = 2'b00;
  logic [1:0]   ForwardB = 2'b00;
  logic [63:0]  ms_alu_result = '0;
  logic [63:0]  ws_alu_result = '0;
  logic         es_allowin;
  logic [4:0]   es_rs1, es_rs2;
  logic         es_to_ms_valid;
  logic [172:0] es_to_ms_bus;
  logic [63:0]  alu_result;
  logic [130:0] bru_to_fs_bus;

  ysyx_22040759_exe_stage dut (
    .clk(clk), .rst(rst), .ms_allowin(ms_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .ms_alu_result(ms_alu_result), .ws_alu_result(ws_alu_result),
    .es_allowin(es_allowin), .es_rs1(es_rs1), .es_rs2(es_rs2),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .alu_result(alu_result), .bru_to_fs_bus(bru_to_fs_bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {store, taken, jump, target, alu}
  logic [193:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [322:0] mk(input logic [63:0] pc, rs1v, rs2v, imm,
                                      input logic [4:0] op, input logic [1:0] s1,
                                      input logic s2, wop, input logic [2:0] br,
                                      input logic jl, jr);
    logic [322:0] b;
    b = '0;
    b[63:0]    = pc;
    b[127:64]  = rs1v;
    b[191:128] = rs2v;
    b[255:192] = imm;
    b[287:256] = 32'h0000_0013;
    b[292:288] = 5'd3;
    b[297:293] = 5'd4;
    b[302:298] = 5'd7;
    b[307:303] = op;
    b[309:308] = s1;
    b[310]     = s2;
    b[311]     = 1'b0;
    b[312]     = 1'b1;
    b[315:313] = 3'd3;
    b[316]     = 1'b1;
    b[317]     = wop;
    b[320:318] = br;
    b[321]     = jl;
    b[322]     = jr;
    return b;
  endfunction

  // driver: offer one instruction for one cycle
  task automatic drive(input logic [322:0] bus, input logic [1:0] fa, fb,
                       input logic [63:0] msr, wsr);
    @(negedge clk);
    ds_to_es_bus   = bus;
    ds_to_es_valid = 1'b1;
    ForwardA       = fa;
    ForwardB       = fb;
    ms_alu_result  = msr;
    ws_alu_result  = wsr;
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [63:0] alu, tgt, input logic tk, jp,
                          input logic [63:0] st);
    exp_q.push_back({st, tk, jp, tgt, alu});
  endtask

  // scoreboard: wait (bounded) for the stage to offer a result, pop and compare
  task automatic collect(input string tag);
    logic [193:0] e;
    for (int i = 0; i < 8 && !es_to_ms_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, ".valid"}, {63'd0, es_to_ms_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".alu"},    alu_result,                 e[63:0]);
      check({tag, ".target"}, bru_to_fs_bus[63:0],        e[127:64]);
      check({tag, ".jump"},   {63'd0, bru_to_fs_bus[129]}, {63'd0, e[128]});
      check({tag, ".taken"},  {63'd0, bru_to_fs_bus[64]},  {63'd0, e[129]});
      check({tag, ".store"},  es_to_ms_bus[63:0],         e[193:130]);
    end
  endtask

  task automatic run(input string tag, input logic [322:0] bus, input logic [1:0] fa, fb,
                     input logic [63:0] msr, wsr, alu, tgt, input logic tk, jp,
                     input logic [63:0] st);
    push_exp(alu, tgt, tk, jp, st);
    drive(bus, fa, fb, msr, wsr);
    collect(tag);
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a, b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a << b[5:0];
      5'd4:    return (a < b) ? 64'd1 : 64'd0;
      5'd5:    return a ^ b;
      5'd6:    return a >> b[5:0];
      5'd8:    return a | b;
      default: return a & b;
    endcase
  endfunction

  logic [4:0] op_list[8] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};

  initial begin
    logic [63:0] a, b, ex;
    logic [4:0]  op;

    repeat (3) @(posedge clk);
    #1;
    check("rst.valid",   {63'd0, es_to_ms_valid},    64'd0);
    check("rst.allowin", {63'd0, es_allowin},        64'd1);
    check("rst.bru_vld", {63'd0, bru_to_fs_bus[130]}, 64'd0);
    check("rst.taken",   {63'd0, bru_to_fs_bus[64]},  64'd0);
    check("rst.rs1",     {59'd0, es_rs1},            64'd0);
    check("rst.rs2",     {59'd0, es_rs2},            64'd0);
    @(negedge clk);
    rst = 1'b1;

    run("add", mk(64'h1000, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
        64'd12, 64'h1000, 0, 0, 64'd7);
    check("bus.rd",      {59'd0, es_to_ms_bus[68:64]},  64'd7);
    check("bus.wr",      {63'd0, es_to_ms_bus[69]},     64'd1);
    check("bus.size",    {61'd0, es_to_ms_bus[72:70]},  64'd3);
    check("bus.mw",      {63'd0, es_to_ms_bus[73]},     64'd1);
    check("bus.mr",      {63'd0, es_to_ms_bus[75]},     64'd0);
    check("bus.pc",      es_to_ms_bus[139:76],          64'h1000);
    check("bus.zero",    {63'd0, es_to_ms_bus[140]},    64'd0);
    check("bus.inst",    {32'd0, es_to_ms_bus[172:141]}, 64'h13);
    check("bru.pc",      bru_to_fs_bus[128:65],         64'h1000);
    check("bru.valid",   {63'd0, bru_to_fs_bus[130]},   64'd1);
    check("es_rs1",      {59'd0, es_rs1},               64'd3);
    check("es_rs2",      {59'd0, es_rs2},               64'd4);

    run("fwd_sub", mk(64'h2000, 999, 7, 1, 1, 0, 1, 0, 0, 0, 0), 2'b10, 2'b01, 100, 64'h55,
        64'd99, 64'h2001, 0, 0, 64'h55);
    run("beq_t", mk(64'h8000_0000, 3, 3, 16, 0, 0, 0, 0, 3'b001, 0, 0), 0, 0, 0, 0,
        64'd6, 64'h8000_0010, 1, 0, 64'd3);
    run("beq_nt", mk(64'h8000_0000, 3, 4, 16, 0, 0, 0, 0, 3'b001, 0, 0), 0, 0, 0, 0,
        64'd7, 64'h8000_0010, 0, 0, 64'd4);
    run("jalr", mk(64'h100, 64'h203, 0, 0, 0, 0, 1, 0, 0, 0, 1), 0, 0, 0, 0,
        64'h104, 64'h202, 1, 1, 64'd0);
    run("jal", mk(64'h400, 9, 0, 64'h20, 1, 0, 1, 0, 0, 1, 0), 0, 0, 0, 0,
        64'h404, 64'h420, 1, 1, 64'd0);
    run("bltu", mk(0, 1, '1, 0, 0, 0, 0, 0, 3'b101, 0, 0), 0, 0, 0, 0,
        64'd0, 64'd0, 1, 0, '1);
    run("blt", mk(0, 1, '1, 0, 0, 0, 0, 0, 3'b011, 0, 0), 0, 0, 0, 0,
        64'd0, 64'd0, 0, 0, '1);
    run("bge_fwd", mk(0, 0, 5, 0, 0, 0, 0, 0, 3'b100, 0, 0), 2'b01, 0, 0, 64'd5,
        64'd10, 64'd0, 1, 0, 64'd5);
    run("addw", mk(0, 64'h7FFF_FFFF, 1, 0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0,
        64'hFFFF_FFFF_8000_0000, 0, 0, 0, 64'd1);
    run("div0", mk(0, 100, 0, 0, 12, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, '1, 0, 0, 0, 0);
    run("rem0", mk(0, 100, 0, 0, 14, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 64'd100, 0, 0, 0, 0);
    run("divw0", mk(0, 64'h1234, 0, 0, 12, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0, '1, 0, 0, 0, 0);
    run("divovf", mk(0, 64'h8000_0000_0000_0000, '1, 0, 12, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
        64'h8000_0000_0000_0000, 0, 0, 0, '1);
    run("removf", mk(0, 64'h8000_0000_0000_0000, '1, 0, 14, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
        64'd0, 0, 0, 0, '1);
    run("remwovf", mk(0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 14, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0,
        64'd0, 0, 0, 0, 64'hFFFF_FFFF);
    run("divu", mk(0, 100, 7, 0, 13, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 64'd14, 0, 0, 0, 64'd7);
    run("rem", mk(0, -64'sd7, 2, 0, 14, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, '1, 0, 0, 0, 64'd2);
    run("sraw", mk(0, 64'h8000_0000, 4, 0, 7, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0,
        64'hFFFF_FFFF_F800_0000, 0, 0, 0, 64'd4);
    run("mul", mk(0, 3, -64'sd2, 0, 11, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0,
        -64'sd6, 0, 0, 0, -64'sd2);
    run("op20", mk(0, 3, 4, 0, 20, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 64'd0, 0, 0, 0, 64'd4);
    run("src1pc", mk(64'h10, 9, 9, 4, 0, 2'b01, 1, 0, 0, 0, 0), 0, 0, 0, 0,
        64'h14, 64'h14, 0, 0, 64'd9);
    run("src1zero", mk(64'h10, 9, 9, 64'h5000, 0, 2'b10, 1, 0, 0, 0, 0), 0, 0, 0, 0,
        64'h5000, 64'h5010, 0, 0, 64'd9);

    for (int i = 0; i < 24; i++) begin
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      op = op_list[$urandom_range(0, 7)];
      ex = ref_alu(op, a, b);
      run("rand", mk(0, a, b, 0, op, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, ex, 0, 0, 0, b);
    end

    // back-pressure: bubble first so the stage is empty, then stall
    @(posedge clk);
    @(negedge clk);
    ms_allowin = 1'b0;
    push_exp(64'd30, 0, 0, 0, 64'd20);
    drive(mk(0, 10, 20, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    check("stall.allowin", {63'd0, es_allowin},     64'd0);
    check("stall.valid",   {63'd0, es_to_ms_valid}, 64'd1);
    drive(mk(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    collect("stall.hold");
    rst = 1'b0;
    #1;
    check("rst_mid.valid",   {63'd0, es_to_ms_valid},    64'd0);
    check("rst_mid.allowin", {63'd0, es_allowin},        64'd1);
    check("rst_mid.bru_vld", {63'd0, bru_to_fs_bus[130]}, 64'd0);
    check("rst_mid.rs1",     {59'd0, es_rs1},            64'd0);
    @(negedge clk);
    rst = 1'b1;
    ms_allowin = 1'b1;
    run("post_rst", mk(0, 6, 3, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 64'd3, 0, 0, 0, 64'd3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
